// File: rtl/fb_scanout.sv
// VGA scan-out engine: pixel clock-enable timing, scaled framebuffer walk with
// incremental addressing, read-latency compensation. Optional page flipping
// at vertical blank is enabled by defining FB_SCANOUT_DOUBLE_BUF_EN.
module fb_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_DIV     = 4,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int ADDR_W      = 15,
  parameter int COLOR_W     = 12,
  parameter int RD_LAT      = 1,
  parameter logic [COLOR_W-1:0] BORDER = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W:0]    fb_rd_addr,
  output logic               fb_rd_en,
  input  logic [COLOR_W-1:0] fb_rd_data,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               front_bank,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = $clog2(PIX_DIV);
  localparam int FB_PIX_W = FB_W << SCALE_SHIFT;
  localparam int FB_PIX_H = FB_H << SCALE_SHIFT;

  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] SMASK    = 32'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  typedef struct packed {
    logic ce;
    logic in_fb;
    logic active;
    logic hs;
    logic vs;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{ce: 1'b0, in_fb: 1'b0, active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [DW-1:0]     div_cnt;
  logic              pix_ce;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [31:0]       h32;
  logic [31:0]       v32;
  logic              h_last;
  logic              v_last;
  logic              h_tex_end;
  logic              v_tex_end;
  logic              active;
  logic              in_fb;
  logic              hs_n;
  logic              vs_n;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_row;
  flags_t            stage_in;
  flags_t            pipe [RD_LAT];
  flags_t            stage_out;

  // pix_ce is gated by rst so the first enable lands on the first cycle after release
  assign pix_ce = ~rst && (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DW'(PIX_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign h32       = 32'(h_cnt);
  assign v32       = 32'(v_cnt);
  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign h_tex_end = ((h32 & SMASK) == SMASK);
  assign v_tex_end = ((v32 & SMASK) == SMASK);
  assign active    = (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
  assign in_fb     = active && (h32 < 32'(FB_PIX_W)) && (v32 < 32'(FB_PIX_H));
  assign hs_n      = !((h32 >= HS_START) && (h32 < HS_END));
  assign vs_n      = !((v32 >= VS_START) && (v32 < VS_END));
  assign next_row  = row_base + FB_W_A;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt    <= '0;
          row_base <= '0;
          addr     <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
          // the next line's start address is the updated row_base, loaded in the same step
          if (v_tex_end) begin
            row_base <= next_row;
            addr     <= next_row;
          end else begin
            addr <= row_base;
          end
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (in_fb && h_tex_end) begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

  assign fb_rd_en    = pix_ce && in_fb;
  assign fb_rd_addr  = {front_bank, addr};
  assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  assign swap_ack = frame_start && swap_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank <= 1'b0;
    end else if (swap_ack) begin
      front_bank <= ~front_bank;
    end
  end
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign swap_ack        = 1'b0;
  assign front_bank      = 1'b0;
`endif

  // flags ride a RD_LAT-deep pipe so they meet fb_rd_data on the same cycle
  assign stage_in  = '{ce: pix_ce, in_fb: in_fb, active: active, hs: hs_n, vs: vs_n};
  assign stage_out = pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe[i] <= FLAGS_IDLE;
      end
    end else begin
      pipe[0] <= stage_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (stage_out.ce) begin
      if (stage_out.in_fb) begin
        rgb <= fb_rd_data;
      end else if (stage_out.active) begin
        rgb <= BORDER;
      end else begin
        rgb <= '0;
      end
      hsync <= stage_out.hs;
      vsync <= stage_out.vs;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced timing grid; honours
// FB_SCANOUT_DOUBLE_BUF_EN for the expected bank/ack behaviour.
module tb_fb_scanout;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int PIX_DIV = 4, S = 1, FB_W = 6, FB_H = 5;
  localparam int ADDR_W = 6, COLOR_W = 12, RD_LAT = 2;
  localparam logic [COLOR_W-1:0] BORDER = 12'hA5C;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE  = H_TOTAL * PIX_DIV;
  localparam int FRAME = V_TOTAL * LINE;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W:0]    fb_rd_addr;
  logic               fb_rd_en;
  logic [COLOR_W-1:0] fb_rd_data;
  logic               swap_req;
  logic               swap_ack;
  logic               front_bank;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] rgb;

  always #5 clk = ~clk;

  fb_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .SCALE_SHIFT(S), .FB_W(FB_W), .FB_H(FB_H),
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .RD_LAT(RD_LAT), .BORDER(BORDER)
  ) dut (
    .clk(clk), .rst(rst),
    .fb_rd_addr(fb_rd_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  // framebuffer RAM model with RD_LAT cycles of read latency
  logic [COLOR_W-1:0] mem [2**(ADDR_W+1)];
  logic [COLOR_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (fb_rd_en) rd_pipe[0] <= mem[fb_rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rd_data = rd_pipe[RD_LAT-1];

  typedef struct {
    int                 due;
    logic [COLOR_W-1:0] rgb;
    logic               hs;
    logic               vs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  logic bank = 1'b0;
  int   acks = 0;
  int   hs_low = 0;
  int   vs_low = 0;
  int   first_hs_fall = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at t=%0d", tag, obs, exp, t);
    end
  endtask

  // check one clk period at its negedge, then move to posedge+1 of the next
  task automatic cycle();
    int p, h, v, idx;
    bit pix, act, in_fb, hs_e, vs_e, fs, ack_e;
    logic [ADDR_W:0] ea;
    logic [COLOR_W-1:0] px;
    exp_t e;
    @(negedge clk);
    pix   = (t % PIX_DIV) == 0;
    p     = t / PIX_DIV;
    h     = p % H_TOTAL;
    v     = (p / H_TOTAL) % V_TOTAL;
    act   = (h < H_ACTIVE) && (v < V_ACTIVE);
    in_fb = act && (h < (FB_W << S)) && (v < (FB_H << S));
    hs_e  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    vs_e  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    fs    = pix && (h == 0) && (v == V_ACTIVE);
    ack_e = DB && fs && (swap_req === 1'b1);
    idx   = (v >> S) * FB_W + (h >> S);
    ea    = {bank, ADDR_W'(idx)};

    chk("frame_start", frame_start, fs);
    chk("swap_ack", swap_ack, ack_e);
    chk("front_bank", front_bank, bank);
    chk("fb_rd_en", fb_rd_en, pix && in_fb);
    if (pix && in_fb) chk("fb_rd_addr", fb_rd_addr, ea);
    if (pix) begin
      px = in_fb ? mem[ea] : (act ? BORDER : '0);
      sb.push_back(exp_t'{due: t + RD_LAT + 1, rgb: px, hs: hs_e, vs: vs_e});
    end
    if (t < RD_LAT + 1) begin
      chk("flush_rgb", rgb, 0);
      chk("flush_hsync", hsync, 1);
      chk("flush_vsync", vsync, 1);
    end
    if (sb.size() > 0 && sb[0].due == t) begin
      e = sb.pop_front();
      chk("rgb", rgb, e.rgb);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
    end
    if (t >= RD_LAT + 1 && t < RD_LAT + 1 + FRAME) begin
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
    end
    if (hsync === 1'b0 && first_hs_fall < 0) first_hs_fall = t;
    if (swap_ack === 1'b1) acks++;
    if (ack_e) bank = ~bank;
    t++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_rgb", rgb, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_swap_ack", swap_ack, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_fb_rd_en", fb_rd_en, 0);
      chk("rst_fb_rd_addr", fb_rd_addr, 0);
      chk("rst_front_bank", front_bank, 0);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    t    = 0;
    bank = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst      = 1'b1;
    swap_req = 1'b0;
    for (int i = 0; i < 2**(ADDR_W+1); i++) mem[i] = COLOR_W'($urandom);

    do_reset(5);

    // frame 0: raise swap_req mid active video, hold across the vblank check
    repeat (5 * LINE) cycle();
    swap_req = 1'b1;
    repeat ((V_ACTIVE - 5) * LINE + 2) cycle();
    swap_req = 1'b0;
    chk("ack_once", acks, DB ? 1 : 0);
    chk("bank_after_swap", front_bank, DB ? 1 : 0);

    // rest of frame 0 and all of frame 1 (displayed from the swapped bank)
    while (t < 2 * FRAME + 100) cycle();
    chk("first_hsync_fall", first_hs_fall, (H_ACTIVE + H_FP) * PIX_DIV + RD_LAT + 1);
    chk("hsync_low_per_frame", hs_low, V_TOTAL * H_SYNC * PIX_DIV);
    chk("vsync_low_per_frame", vs_low, V_SYNC * H_TOTAL * PIX_DIV);
    chk("ack_total_2frames", acks, DB ? 1 : 0);

    // swap_req toggling across the frame-2 check
    for (int k = 0; k < 12; k++) begin
      swap_req = k[0];
      repeat (37) cycle();
    end
    swap_req = 1'b0;
    repeat (3 * LINE) cycle();

    // mid-frame reset, then a held request swaps at the next check
    do_reset(3);
    acks = 0;
    swap_req = 1'b1;
    repeat (FRAME + LINE) cycle();
    swap_req = 1'b0;
    chk("ack_after_reset", acks, DB ? 1 : 0);
    chk("bank_after_reset_swap", front_bank, DB ? 1 : 0);
    repeat (LINE) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Parametrised VGA scan-out engine. It replaces the fixed divide-by-4 pixel clock, the fixed ×4 multiply-based framebuffer addressing and the separately clocked timing generator with a single-clock block. The block generates VGA timing from a pixel clock-enable, walks a scaled framebuffer with incremental addressing, and compensates the block-RAM read latency. It also supports double-buffered page flipping at vertical blank. It sits between the framebuffer read port and the VGA pins; the renderer writes the back bank while this block displays the front bank.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- PIX_DIV, 4, clk cycles per pixel (≥ 2)
- SCALE_SHIFT, 2, each framebuffer texel is 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels
- FB_W / FB_H, 160 / 120, framebuffer size in texels
- ADDR_W, 15, per-bank address width (FB_W*FB_H ≤ 2^ADDR_W)
- COLOR_W, 12, RGB444 pixel width
- RD_LAT, 1, framebuffer read latency in clk cycles (1..PIX_DIV-1)
- BORDER, 12'h000, colour shown in the active area outside the scaled framebuffer

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-high
- fb_rd_addr  out  ADDR_W+1  read address; MSB = front bank, low ADDR_W bits = texel index
- fb_rd_en  out  1  high on the clk cycle the address is presented
- fb_rd_data  in  COLOR_W  read data, valid RD_LAT cycles after fb_rd_en
- swap_req  in  1  level; renderer has finished the back bank
- swap_ack  out  1  one-clk pulse when the swap is taken
- front_bank  out  1  bank currently displayed
- frame_start  out  1  one-clk pulse at the start of vertical blank
- hsync, vsync  out  1  active-low sync
- rgb  out  COLOR_W  pixel colour, 0 outside active video

## Operation
- pix_ce: a free-running divider that asserts for 1 clk every PIX_DIV cycles; the first pix_ce occurs on the cycle after reset release. All timing counters advance only on pix_ce.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Sync window: hsync is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync follows the same rule on v_cnt.
- Active video is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. The in-framebuffer region is additionally h_cnt < FB_W<<SCALE_SHIFT and v_cnt < FB_H<<SCALE_SHIFT.
- Addressing is incremental; no multipliers.
  - A row_base register is cleared at frame wrap.
  - row_base += FB_W when a line ends and the low SCALE_SHIFT bits of v_cnt are all 1.
  - At line start, addr = row_base. addr increments on each pix_ce where the low SCALE_SHIFT bits of h_cnt are all 1, inside the in-framebuffer region.
- fb_rd_en pulses on the pix_ce cycle of every in-framebuffer pixel.
- Output stage: the in-region, active and sync flags are delayed RD_LAT clk cycles so they line up with fb_rd_data. On that cycle, rgb is registered as follows:
  - fb_rd_data if in-region;
  - otherwise BORDER if active;
  - otherwise 0.
  - hsync and vsync are registered on the same edge.
- Swap check: at the pix_ce where h_cnt == 0 and v_cnt == V_ACTIVE, frame_start pulses.
  - If swap_req is high on that cycle, front_bank toggles and swap_ack pulses on the same clk cycle.
  - If swap_req is high at any other time, nothing happens until the next check.
  - The requester must drop swap_req within one frame of the ack; if it stays high, the block swaps again at the next frame.
- Bank changes never take effect in active video; the MSB of fb_rd_addr is constant across visible lines.

## Timing
- Reset values: counters 0, front_bank 0, row_base 0, hsync 1, vsync 1, rgb 0, swap_ack 0, frame_start 0, fb_rd_en 0, fb_rd_addr 0.
- rst asserted mid-frame: all state returns to reset values on the next clk edge. The output pipeline is flushed; no stale pixels appear.
- Pixel-to-pin latency: rgb, hsync and vsync appear RD_LAT+1 clk cycles after the pix_ce on which the corresponding h_cnt is current. All three share that latency, so they stay aligned.
- Line period: H_TOTAL*PIX_DIV clk cycles (3200 at defaults). Frame period: V_TOTAL*H_TOTAL*PIX_DIV clk cycles (1 680 000 at defaults).

## Configuration
- FB_SCANOUT_DOUBLE_BUF_EN defined: bank swapping as described above.
- FB_SCANOUT_DOUBLE_BUF_EN not defined:
  - front_bank is held at 0 and the fb_rd_addr MSB is 0;
  - swap_req is ignored and swap_ack stays 0;
  - frame_start is still generated.

## Test plan
- Reset: hold rst for 5 cycles, then release → outputs at reset values; first pix_ce on the first cycle after release; hsync first falls 656*4 + RD_LAT + 1 cycles after release.
- Sync timing: run 2 frames → hsync low for 384 clk every 3200; vsync low for 6400 clk every 1 680 000.
- Addressing: line 0 → fb_rd_addr low bits 0,0,0,0,1,1,1,1,…,159. Lines 1–3 repeat 0..159. Line 4 starts at 160. Line 476 ends at 19199.
- Border: SCALE_SHIFT=1 (320×240 region in 640×480) → rgb = BORDER for h_cnt 320..639 and for v_cnt ≥ 240; fb_rd_en stays low there.
- Swap: raise swap_req at line 100 → swap_ack exactly once at v_cnt 480, h_cnt 0; front_bank 0→1; lines 0–479 of the next frame read bank 1; rst mid-frame returns front_bank to 0.
- Macro off: toggle swap_req repeatedly → swap_ack never pulses; fb_rd_addr MSB always 0.
